imm_stage_ctrl: RTL
===================

# imm_stage_ctrl

Decode-stage controller that sequences the 16-bit immediate extender for each fetched instruction. It classifies the opcode, selects the extension format, and registers the extended immediate and precomputed branch target into a valid/ready pipeline slot. The slot sits between instruction fetch (IF/ID) and the execute stage (ID/EX), with stall and flush handling.

## Interface
- No parameters. Data width is fixed at 16 and selector codes are the `IM*` constants from config.v.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction word and PC present
- in_ready  out  1  slot can accept this cycle
- in_instr  in  16  instruction word
- in_pc  in  16  PC of the instruction (word address)
- flush  in  1  discard held and incoming instruction (branch mispredict)
- out_valid  out  1  registered result valid
- out_ready  in  1  execute stage consumes result
- out_sel  out  3  `IM*` code applied
- out_imm  out  16  extended immediate
- out_target  out  16  in_pc + 1 + extended immediate
- out_instr  out  16  registered instruction word

## Operation
- Classification uses in_instr[15:11] (op); applied combinationally to the incoming word:
  - 01001 ADDIU, 00100 BEQZ, 00101 BNEZ, 01100 with [10:8]=000 BTEQZ → `IM8` on [7:0]
  - 01000 ADDIU3 → `IM4` on [3:0]
  - 00010 B → `IM11` on [10:0]
  - 10011 LW, 11011 SW → `IM5` on [4:0]
  - 00110 shifts (SLL/SRL/SRA): [4:2]≠000 → `IM3`, value = [4:2] zero-extended (bit 4 is the top bit of the 3-bit field; shift amounts are unsigned here, so sign fill is not used); [4:2]=000 → `IM_TO8`, imm = 0x0008
  - all other ops → `IM0`, imm = 0x0000
- Sign extension: `IM8`, `IM4`, `IM11` and `IM5` replicate the field's MSB into bits [15:n].
- out_target = in_pc + 16'd1 + imm, computed modulo 2^16 with silent wrap. It is valid for every op; the consumer ignores it for non-branches.
- One-entry slot:
  - in_ready = !out_valid || out_ready
  - Load occurs when in_valid && in_ready && !flush.
  - On load, all out_* fields update together.
- Hold: while out_valid && !out_ready, every out_* field is frozen and in_ready=0.
- Flush: out_valid clears next cycle, and an instruction offered in the same cycle is dropped. Data fields may keep stale values.
- Simultaneous consume and load (out_valid && out_ready && in_valid): the new entry replaces the old in the same edge, giving back-to-back throughput of 1/cycle.

## Timing
- Reset values: out_valid=0, out_sel=`IM0`, out_imm=0x0000, out_target=0x0000, out_instr=0x0800 (NOP).
- in_ready is combinational from out_valid/out_ready; it is 1 during reset and the cycle after.
- Latency is 1 cycle: instruction accepted at edge N appears on out_* after edge N.
- Priority per edge: rst > flush > load/hold.
- rst asserted mid-hold drops the held entry; outputs return to reset values after the edge.
- No combinational path from in_* to out_*.

## Test plan
- Reset then idle → out_valid=0, out_imm=0x0000, out_instr=0x0800, in_ready=1.
- ADDIU 0x49F0 (imm 0xF0) at pc 0x0010, out_ready=1 → next cycle out_sel=`IM8`, out_imm=0xFFF0, out_target=0x0001 (wrap check).
- Stream of B 0x17FF, LW 0x9B11, SLL with sa=0 (0x3000), SLL with sa=3 (0x300C), back-to-back with out_ready=1 → imm 0xFFFF, 0xFFF1, 0x0008, 0x0003 on consecutive cycles; no bubbles.
- Backpressure: load ADDIU3 0x410E, hold out_ready=0 for 3 cycles while presenting another word → in_ready=0, out_imm=0xFFFE stable; release → second word appears the next cycle.
- Flush while out_valid=1 and in_valid=1 → out_valid=0 next cycle and the offered word is never output.
- rst during backpressure hold → all outputs at reset values the next cycle and in_ready=1.

Source files
------------

// File: rtl/imm_stage_ctrl.sv
// imm_stage_ctrl
// Decode-stage controller for the 16-bit immediate extender. Each incoming
// instruction word is classified by its opcode. The immediate is extracted and
// extended, and the branch target (pc + 1 + imm) is precomputed. All of this is
// registered into a one-entry valid/ready slot that sits between IF/ID and ID/EX.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    instruction word and PC present
//   in_ready    slot can accept this cycle (combinational from slot state)
//   in_instr    16-bit instruction word
//   in_pc       PC of the instruction (word address)
//   flush       discard held and incoming instruction
//   out_valid   registered result valid
//   out_ready   execute stage consumes result
//   out_sel     extension selector code applied
//   out_imm     extended immediate
//   out_target  in_pc + 1 + extended immediate (wraps modulo 2^16)
//   out_instr   registered instruction word
module imm_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_sel,
    output logic [15:0] out_imm,
    output logic [15:0] out_target,
    output logic [15:0] out_instr
);

    // Extension selector codes
    localparam logic [2:0] IM0    = 3'd0;
    localparam logic [2:0] IM3    = 3'd1;
    localparam logic [2:0] IM4    = 3'd2;
    localparam logic [2:0] IM5    = 3'd3;
    localparam logic [2:0] IM8    = 3'd4;
    localparam logic [2:0] IM11   = 3'd5;
    localparam logic [2:0] IM_TO8 = 3'd6;

    localparam logic [15:0] NOP_WORD = 16'h0800;

    // Opcodes (instr[15:11])
    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_T      = 5'b01100;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW     = 5'b11011;

    logic        valid_reg;
    logic [2:0]  sel_reg;
    logic [15:0] imm_reg;
    logic [15:0] target_reg;
    logic [15:0] instr_reg;

    logic [2:0]  sel_next;
    logic [15:0] imm_next;
    logic [15:0] target_next;
    logic [4:0]  op;
    logic        load;

    // Sign-extended candidates for each signed field width.
    logic [15:0] sext4;
    logic [15:0] sext5;
    logic [15:0] sext8;
    logic [15:0] sext11;

    assign op = in_instr[15:11];

    // Low bits come straight from the field. Upper bits replicate the field MSB.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sext
            assign sext4[gi]  = (gi < 4)  ? in_instr[gi] : in_instr[3];
            assign sext5[gi]  = (gi < 5)  ? in_instr[gi] : in_instr[4];
            assign sext8[gi]  = (gi < 8)  ? in_instr[gi] : in_instr[7];
            assign sext11[gi] = (gi < 11) ? in_instr[gi] : in_instr[10];
        end
    endgenerate

    // Opcode classification and immediate selection for the incoming word.
    always_comb begin
        sel_next = IM0;
        imm_next = 16'h0000;
        unique case (op)
            OP_ADDIU, OP_BEQZ, OP_BNEZ: begin
                sel_next = IM8;
                imm_next = sext8;
            end
            OP_T: begin
                // Only BTEQZ ([10:8]=000) carries an 8-bit offset in this group.
                if (in_instr[10:8] == 3'b000) begin
                    sel_next = IM8;
                    imm_next = sext8;
                end
            end
            OP_ADDIU3: begin
                sel_next = IM4;
                imm_next = sext4;
            end
            OP_B: begin
                sel_next = IM11;
                imm_next = sext11;
            end
            OP_LW, OP_SW: begin
                sel_next = IM5;
                imm_next = sext5;
            end
            OP_SHIFT: begin
                // A shift amount of 0 encodes a shift by 8. Shift amounts are unsigned.
                if (in_instr[4:2] == 3'b000) begin
                    sel_next = IM_TO8;
                    imm_next = 16'h0008;
                end else begin
                    sel_next = IM3;
                    imm_next = {13'd0, in_instr[4:2]};
                end
            end
            default: begin
                sel_next = IM0;
                imm_next = 16'h0000;
            end
        endcase
    end

    // Wraps silently modulo 2^16.
    assign target_next = in_pc + 16'd1 + imm_next;

    assign in_ready = !valid_reg || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            sel_reg    <= IM0;
            imm_reg    <= 16'h0000;
            target_reg <= 16'h0000;
            instr_reg  <= NOP_WORD;
        end else if (flush) begin
            // Data fields keep their stale values. Only validity is cleared.
            valid_reg <= 1'b0;
        end else if (load) begin
            // This also covers consume+load in the same edge (back-to-back).
            valid_reg  <= 1'b1;
            sel_reg    <= sel_next;
            imm_reg    <= imm_next;
            target_reg <= target_next;
            instr_reg  <= in_instr;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid  = valid_reg;
    assign out_sel    = sel_reg;
    assign out_imm    = imm_reg;
    assign out_target = target_reg;
    assign out_instr  = instr_reg;

endmodule
